vga_timing_ctrl: RTL and testbench



---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing_ctrl_if.sv | 33 +++
 rtl/vga_pixel_tick.sv | 42 ++++
 rtl/vga_timing_ctrl.sv | 104 ++++++++++
 tb/tb_vga_timing_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 Hz timing constants and the game-state enum used by
// the screen and game blocks.
package vga_pkg;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Inclusive sync windows: 656..751 and 490..491 for the default timing.
    localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    typedef enum logic [1:0] {
        INICIAL = 2'd0,
        JOGO    = 2'd1,
        VITORIA = 2'd2,
        DERROTA = 2'd3
    } game_state_t;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Bundle between the timing controller, the screen-selection block and the DAC pins.
interface vga_timing_ctrl_if;

    logic [9:0] h_counter;
    logic [9:0] v_counter;
    logic [7:0] R_in;
    logic [7:0] G_in;
    logic [7:0] B_in;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;
    logic       frame_start;

    modport master (
        output h_counter, v_counter,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
        output VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start,
        input  R_in, G_in, B_in
    );

    modport slave (
        input  h_counter, v_counter,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
        input  VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start,
        output R_in, G_in, B_in
    );

endinterface

// File: rtl/vga_pixel_tick.sv
// System-clock divider: one-clk pixel tick every CLK_DIV clocks plus the DAC pixel clock.
module vga_pixel_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic vga_clk
);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_pixel_tick: CLK_DIV must be at least 2");
    end

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = div + DIV_W'(1);
        if (div == DIV_LAST) begin
            div_next = '0;
        end
    end

    assign tick = (div == DIV_LAST);

    // vga_clk is decoded from div_next so the flop always equals (div >= CLK_DIV/2).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div     <= '0;
            vga_clk <= 1'b0;
        end else begin
            div     <= div_next;
            vga_clk <= (div_next >= DIV_HALF);
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel/line counters, sync/blank decode and the registered
// colour/sync output stage feeding the DAC.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_ctrl_if.master vga
);

    localparam logic [9:0] H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FROM = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_TO   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FROM = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_TO   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;
    logic       hs_n;
    logic       vs_n;
    logic       frame_wrap;
    logic [7:0] r_q, g_q, b_q;
    logic       blank_n_q, hs_q, vs_q, frame_start_q;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .vga_clk (vga.VGA_CLK)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        active     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_n       = !((h_cnt >= HS_FROM) && (h_cnt <= HS_TO));
        vs_n       = !((v_cnt >= VS_FROM) && (v_cnt <= VS_TO));
        frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

    // Colour and sync share the tick edge, so they leave one pixel behind the counters together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            blank_n_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= tick && frame_wrap;
            if (tick) begin
                r_q       <= active ? vga.R_in : '0;
                g_q       <= active ? vga.G_in : '0;
                b_q       <= active ? vga.B_in : '0;
                blank_n_q <= active;
                hs_q      <= hs_n;
                vs_q      <= vs_n;
            end
        end
    end

    assign vga.h_counter   = h_cnt;
    assign vga.v_counter   = v_cnt;
    assign vga.VGA_R       = r_q;
    assign vga.VGA_G       = g_q;
    assign vga.VGA_B       = b_q;
    assign vga.VGA_BLANK_N = blank_n_q;
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl using a shrunken raster so several whole frames fit in a short run.
module tb_vga_timing_ctrl;

    localparam int unsigned CD = 2;
    localparam int unsigned HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int unsigned VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #10 clk = ~clk;

    vga_timing_ctrl_if vga ();

    vga_timing_ctrl #(
        .CLK_DIV   (CD),
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vga)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned e;             // clk edges since reset release
    int unsigned k;             // pixel ticks since reset release
    int unsigned fs_seen = 0;
    int unsigned fs_exp = 0;
    int unsigned mode = 0;
    logic [7:0]  drv_r, drv_g, drv_b;
    logic [7:0]  cap_r, cap_g, cap_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d tick %0d)", tag, obs, exp, e, k);
        end
    endtask

    // Reference: after k ticks the raster position is k mod FT; outputs show pixel k-1.
    task automatic check_outputs(input bit tick_now);
        int unsigned p, pp, ph, pv;
        bit act, hs_exp, vs_exp, fs;
        p = k % FT;
        check("h_counter", 32'(vga.h_counter), p % HT);
        check("v_counter", 32'(vga.v_counter), p / HT);
        if (k == 0) begin
            act = 1'b0; hs_exp = 1'b1; vs_exp = 1'b1;
        end else begin
            pp = (k - 1) % FT;
            ph = pp % HT;
            pv = pp / HT;
            act    = (ph < HV) && (pv < VV);
            hs_exp = !((ph >= HV + HF) && (ph < HV + HF + HS));
            vs_exp = !((pv >= VV + VF) && (pv < VV + VF + VS));
        end
        check("VGA_R", 32'(vga.VGA_R), act ? 32'(cap_r) : 32'd0);
        check("VGA_G", 32'(vga.VGA_G), act ? 32'(cap_g) : 32'd0);
        check("VGA_B", 32'(vga.VGA_B), act ? 32'(cap_b) : 32'd0);
        check("VGA_BLANK_N", 32'(vga.VGA_BLANK_N), 32'(act));
        check("VGA_HS", 32'(vga.VGA_HS), 32'(hs_exp));
        check("VGA_VS", 32'(vga.VGA_VS), 32'(vs_exp));
        check("VGA_SYNC_N", 32'(vga.VGA_SYNC_N), 32'd0);
        check("VGA_CLK", 32'(vga.VGA_CLK), 32'((e % CD) >= CD / 2));
        fs = tick_now && (k > 0) && (k % FT == 0);
        if (fs) fs_exp++;
        check("frame_start", 32'(vga.frame_start), 32'(fs));
    endtask

    task automatic drive_inputs();
        if (mode == 0) begin
            drv_r = 8'((k % FT) % HT);
            drv_g = 8'hAA;
            drv_b = 8'h55;
        end else begin
            drv_r = 8'($urandom);
            drv_g = 8'($urandom);
            drv_b = 8'($urandom);
        end
        vga.R_in = drv_r;
        vga.G_in = drv_g;
        vga.B_in = drv_b;
    endtask

    task automatic step();
        bit tick_now;
        @(posedge clk);
        #1;
        e++;
        tick_now = (e % CD == 0);
        if (tick_now) begin
            k++;
            cap_r = drv_r;
            cap_g = drv_g;
            cap_b = drv_b;
        end
        if (vga.frame_start) fs_seen++;
        check_outputs(tick_now);
        drive_inputs();
    endtask

    initial begin
        bit found;
        e = 0; k = 0;
        cap_r = '0; cap_g = '0; cap_b = '0;
        drive_inputs();

        // Held in reset through several edges.
        repeat (3) @(posedge clk);
        #1 check_outputs(1'b0);

        @(negedge clk);
        reset = 1'b0;
        e = 0; k = 0;

        // Counter-derived colour for three frames, then random colour changing every clk.
        repeat (3 * FT * CD) step();
        mode = 1;
        repeat (2 * FT * CD) step();

        // Reset between ticks in the middle of the visible area.
        found = 1'b0;
        for (int i = 0; i < int'(2 * FT * CD); i++) begin
            step();
            if ((k % FT == 5 * HT + 10) && (e % CD != 0)) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_reset_reach", 32'(found), 32'd1);
        #3 reset = 1'b1;
        #1;
        e = 0; k = 0;
        cap_r = '0; cap_g = '0; cap_b = '0;
        check_outputs(1'b0);
        repeat (2) @(posedge clk);
        #1 check_outputs(1'b0);
        @(negedge clk);
        reset = 1'b0;
        e = 0; k = 0;
        mode = 0;
        drive_inputs();
        repeat (FT * CD + FT) step();

        check("frame_start_count", 32'(fs_seen), 32'(fs_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
